ground_scroll_ctrl: RTL and testbench
=====================================

# ground_scroll_ctrl

Frame-level controller that sequences ground scrolling across game phases. It replaces the ad-hoc speed and position registers in the ground renderer. It detects the frame-refresh strobe and runs the game-phase state machine (READY/RUN/DYING/OVER). On each frame it advances the ground offset modulo the ground tile period and ramps scroll speed during play. Its outputs feed the ground and pipe renderers and the top-level game logic.

## Interface
Parameters:
- GROUND_PERIOD, 336: ground texture period in pixels; position wraps at this value.
- SPEED_INIT, 3: scroll speed (px/frame) in READY and at RUN entry.
- SPEED_MAX, 8: speed ceiling; must be ≤15.
- RAMP_FRAMES, 600: RUN frames between speed increments; 1..1023.
- DEATH_FRAMES, 30: frames spent in DYING before OVER; 1..63.

Ports:
- clk  in  1  pixel clock (clkdiv[0] at top level).
- rst  in  1  asynchronous, active-high reset.
- fresh  in  1  frame strobe from VGA timing; asynchronous to logic, low during blanking.
- start  in  1  one-cycle start/flap request (debounced upstream).
- collide  in  1  level, bird collision with pipe or ground.
- game_status  out  1  1 only in RUN.
- state  out  2  READY=0, RUN=1, DYING=2, OVER=3.
- ground_position  out  10  current ground scroll offset, 0..GROUND_PERIOD-1.
- speed  out  4  current scroll speed.
- frame_tick  out  1  one-cycle pulse per detected frame.

## Operation
- fresh passes through a 2-FF synchronizer. frame_tick fires on the synchronized falling edge, i.e. at blanking start.
- Position update on frame_tick, only in READY and RUN:
  - sum = ground_position + speed, computed 11-bit.
  - ground_position <= (sum ≥ GROUND_PERIOD) ? sum − GROUND_PERIOD : sum.
  - No update in DYING or OVER; position freezes.
- State machine:
  - READY: attract scroll at SPEED_INIT. start → RUN, clears ramp counter, speed stays SPEED_INIT. collide is ignored.
  - RUN: on each frame_tick the ramp counter increments. When it reaches RAMP_FRAMES−1 it clears and speed <= min(speed+1, SPEED_MAX). collide → DYING, clears death counter. start is ignored.
  - DYING: death counter increments per frame_tick. On reaching DEATH_FRAMES−1 → OVER.
  - OVER: start → READY, ground_position <= 0, speed <= SPEED_INIT.
- Simultaneous events:
  - In RUN, collide takes priority over a speed ramp in the same cycle. The transition still occurs, but the speed increment is suppressed.
  - A frame_tick in the same cycle as a RUN→DYING transition does not move the position.
  - A frame_tick in the same cycle as a READY→RUN transition uses the READY rule: it scrolls at SPEED_INIT.

## Timing
- Reset values: state=READY, game_status=0, ground_position=0, speed=SPEED_INIT, frame_tick=0, synchronizer FFs=1, counters=0.
- frame_tick is asserted on the 3rd rising clk edge after fresh falls; width is 1 cycle.
- ground_position and speed are registered and update on the edge after frame_tick is sampled. Both are stable for the rest of the frame.
- State transitions take effect 1 cycle after start or collide is sampled. game_status is decoded from the state register (no extra latency).
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous). After release, the first frame_tick requires a new falling edge of fresh.

## Configuration
- SCROLL_RAMP_EN defined: speed ramps during RUN as described.
- SCROLL_RAMP_EN undefined:
  - The ramp counter is removed.
  - speed is constant SPEED_INIT in all states.
  - All other behaviour is identical.

## Test plan
- Reset, toggle fresh 5 frames with no start → state=READY, ground_position=15, speed=3, game_status=0.
- From ground_position=334 with speed=3, one frame → 1 (wrap); from 333 → 0.
- start, then 1200 frames in RUN with RAMP_FRAMES=600 (ramp enabled) → speed=5.
- Repeat with SCROLL_RAMP_EN undefined → speed=3.
- collide in RUN and frame_tick in the same cycle → state=DYING, position unchanged. After 30 frames → OVER, position still frozen. start → READY, position 0, speed 3.
- Assert rst mid-RUN with position=200 and speed=6 → immediate READY/0/3. The first frame_tick appears only after the next fresh falling edge, 3 clk later.

Source files
------------

// File: rtl/ground_scroll_ctrl_if.sv
// Bundles the frame-strobe/control inputs and scroll-status outputs of ground_scroll_ctrl.
// master: the driver of fresh/start/collide (top-level game logic or a bench).
// slave:  the ground_scroll_ctrl block itself.
interface ground_scroll_ctrl_if;
  logic       fresh;
  logic       start;
  logic       collide;
  logic       game_status;
  logic [1:0] state;
  logic [9:0] ground_position;
  logic [3:0] speed;
  logic       frame_tick;

  modport master (
    output fresh,
    output start,
    output collide,
    input  game_status,
    input  state,
    input  ground_position,
    input  speed,
    input  frame_tick
  );

  modport slave (
    input  fresh,
    input  start,
    input  collide,
    output game_status,
    output state,
    output ground_position,
    output speed,
    output frame_tick
  );
endinterface

// File: rtl/ground_scroll_ctrl.sv
// ground_scroll_ctrl: frame-level ground scroll sequencer.
// Detects the frame strobe, runs the READY/RUN/DYING/OVER phase machine and
// advances the ground offset modulo GROUND_PERIOD once per frame.
// Optional feature macro: SCROLL_RAMP_EN -- when defined, speed ramps up by one
// every RAMP_FRAMES frames in RUN (capped at SPEED_MAX); when undefined the
// ramp counter is absent and speed is fixed at SPEED_INIT.
module ground_scroll_ctrl #(
  parameter int unsigned GROUND_PERIOD = 336,
  parameter int unsigned SPEED_INIT    = 3,
  parameter int unsigned SPEED_MAX     = 8,
  parameter int unsigned RAMP_FRAMES   = 600,
  parameter int unsigned DEATH_FRAMES  = 30
) (
  input logic               clk,
  input logic               rst,
  ground_scroll_ctrl_if.slave bus
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned SUM_W   = 11;
  localparam int unsigned SPD_W   = 4;
  localparam int unsigned RAMP_W  = 10;
  localparam int unsigned DEATH_W = 6;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_RUN   = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Reject parameter sets the counter and speed widths cannot represent.
  if (SPEED_MAX > 15 || SPEED_INIT > SPEED_MAX ||
      RAMP_FRAMES < 1 || RAMP_FRAMES > 1023 ||
      DEATH_FRAMES < 1 || DEATH_FRAMES > 63 ||
      GROUND_PERIOD < 1 || GROUND_PERIOD > 1023) begin : g_param_check
    $error("ground_scroll_ctrl: parameter out of range");
  end

  state_t             state_q;
  logic [POS_W-1:0]   pos_q;
  logic [SPD_W-1:0]   speed_q;
  logic [DEATH_W-1:0] death_cnt_q;
  logic               sync_q1;
  logic               sync_q2;
  logic               sync_q3;
  logic               frame_tick_q;
  logic [SUM_W-1:0]   sum_c;
  logic [POS_W-1:0]   next_pos_c;

`ifdef SCROLL_RAMP_EN
  logic [RAMP_W-1:0]  ramp_cnt_q;
  logic [SPD_W-1:0]   speed_inc_c;
`endif

  // Two-flop synchronizer on fresh plus a history flop; tick on the synchronized falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1      <= 1'b1;
      sync_q2      <= 1'b1;
      sync_q3      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      sync_q1      <= bus.fresh;
      sync_q2      <= sync_q1;
      sync_q3      <= sync_q2;
      frame_tick_q <= sync_q3 & ~sync_q2;
    end
  end

  // Next scroll offset: 11-bit sum folded back into one ground period.
  always_comb begin
    sum_c      = SUM_W'(pos_q) + SUM_W'(speed_q);
    next_pos_c = POS_W'(sum_c);
    if (sum_c >= SUM_W'(GROUND_PERIOD)) begin
      next_pos_c = POS_W'(sum_c - SUM_W'(GROUND_PERIOD));
    end
  end

`ifdef SCROLL_RAMP_EN
  // Saturating speed increment used at each ramp boundary.
  always_comb begin
    speed_inc_c = speed_q;
    if (speed_q < SPD_W'(SPEED_MAX)) begin
      speed_inc_c = SPD_W'(speed_q + SPD_W'(1));
    end
  end
`else
  assign speed_q = SPD_W'(SPEED_INIT);
`endif

  // Game-phase state machine with scroll offset, speed ramp and death timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_READY;
      pos_q       <= '0;
      death_cnt_q <= '0;
`ifdef SCROLL_RAMP_EN
      speed_q     <= SPD_W'(SPEED_INIT);
      ramp_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_READY: begin
          // Attract scroll; a tick coinciding with start still scrolls at the READY speed.
          if (frame_tick_q) begin
            pos_q <= next_pos_c;
          end
          if (bus.start) begin
            state_q <= ST_RUN;
`ifdef SCROLL_RAMP_EN
            ramp_cnt_q <= '0;
            speed_q    <= SPD_W'(SPEED_INIT);
`endif
          end
        end
        ST_RUN: begin
          // Collision wins over both the frame scroll and any ramp step in the same cycle.
          if (bus.collide) begin
            state_q     <= ST_DYING;
            death_cnt_q <= '0;
          end else if (frame_tick_q) begin
            pos_q <= next_pos_c;
`ifdef SCROLL_RAMP_EN
            if (ramp_cnt_q == RAMP_W'(RAMP_FRAMES - 1)) begin
              ramp_cnt_q <= '0;
              speed_q    <= speed_inc_c;
            end else begin
              ramp_cnt_q <= RAMP_W'(ramp_cnt_q + RAMP_W'(1));
            end
`endif
          end
        end
        ST_DYING: begin
          // Ground frozen; count frames until the game-over screen.
          if (frame_tick_q) begin
            if (death_cnt_q == DEATH_W'(DEATH_FRAMES - 1)) begin
              state_q <= ST_OVER;
            end else begin
              death_cnt_q <= DEATH_W'(death_cnt_q + DEATH_W'(1));
            end
          end
        end
        ST_OVER: begin
          // Wait for start, then rewind the ground for a fresh attract loop.
          if (bus.start) begin
            state_q <= ST_READY;
            pos_q   <= '0;
`ifdef SCROLL_RAMP_EN
            speed_q <= SPD_W'(SPEED_INIT);
`endif
          end
        end
        default: begin
          state_q <= ST_READY;
        end
      endcase
    end
  end

  // Output mapping; game_status is a direct decode of the state register.
  assign bus.state           = state_q;
  assign bus.game_status     = (state_q == ST_RUN);
  assign bus.ground_position = pos_q;
  assign bus.speed           = speed_q;
  assign bus.frame_tick      = frame_tick_q;

endmodule

// File: tb/tb_ground_scroll_ctrl.sv
// Directed bench for ground_scroll_ctrl: attract scroll, wrap, ramp, collision,
// game-over, restart and asynchronous reset, with hand-computed expectations.
module tb_ground_scroll_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_spd_600;
  int   exp_spd_1200;
  int   exp_pos_1200;
  int   pre_wrap_frames;
  int   exp_pos_wrap;

  ground_scroll_ctrl_if bus();

  ground_scroll_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input int exp);
    checks++;
    assert (obs === 16'(exp)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame: fresh low for 8 cycles then high for 8; c/s are driven in the tick cycle.
  task automatic frame(input logic c, input logic s, input bit chk);
    @(negedge clk);
    bus.fresh = 1'b0;
    repeat (2) @(negedge clk);
    if (chk) check("tick_early", 16'(bus.frame_tick), 0);
    @(negedge clk);
    if (chk) check("tick_pulse", 16'(bus.frame_tick), 1);
    bus.collide = c;
    bus.start   = s;
    @(negedge clk);
    bus.collide = 1'b0;
    bus.start   = 1'b0;
    if (chk) check("tick_width", 16'(bus.frame_tick), 0);
    repeat (4) @(negedge clk);
    bus.fresh = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef SCROLL_RAMP_EN
    exp_spd_600     = 4;
    exp_spd_1200    = 5;
    exp_pos_1200    = 168;
    pre_wrap_frames = 33;
    exp_pos_wrap    = 2;
`else
    exp_spd_600     = 3;
    exp_spd_1200    = 3;
    exp_pos_1200    = 240;
    pre_wrap_frames = 31;
    exp_pos_wrap    = 0;
`endif
    bus.fresh   = 1'b1;
    bus.start   = 1'b0;
    bus.collide = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_state",  16'(bus.state), 0);
    check("rst_status", 16'(bus.game_status), 0);
    check("rst_pos",    16'(bus.ground_position), 0);
    check("rst_speed",  16'(bus.speed), 3);
    check("rst_tick",   16'(bus.frame_tick), 0);
    rst = 1'b0;
    @(negedge clk);

    // Attract scroll in READY
    frame(1'b0, 1'b0, 1'b1);
    check("ready_pos_1", 16'(bus.ground_position), 3);
    frames(4);
    check("ready_pos_5",    16'(bus.ground_position), 15);
    check("ready_state_5",  16'(bus.state), 0);
    check("ready_speed_5",  16'(bus.speed), 3);
    check("ready_status_5", 16'(bus.game_status), 0);
    frames(106);
    check("ready_pos_333", 16'(bus.ground_position), 333);
    frame(1'b0, 1'b0, 1'b1);
    check("wrap_333_to_0", 16'(bus.ground_position), 0);

    // Enter RUN
    pulse_start();
    check("run_state",  16'(bus.state), 1);
    check("run_status", 16'(bus.game_status), 1);
    check("run_speed",  16'(bus.speed), 3);
    check("run_pos",    16'(bus.ground_position), 0);
    frames(600);
    check("run_pos_600",   16'(bus.ground_position), 120);
    check("run_speed_600", 16'(bus.speed), exp_spd_600);
    frames(600);
    check("run_pos_1200",   16'(bus.ground_position), exp_pos_1200);
    check("run_speed_1200", 16'(bus.speed), exp_spd_1200);
    frames(pre_wrap_frames);
    check("run_pos_prewrap", 16'(bus.ground_position), 333);
    frame(1'b0, 1'b0, 1'b1);
    check("run_wrap", 16'(bus.ground_position), exp_pos_wrap);

    // Collision in the tick cycle: DYING, no scroll
    frame(1'b1, 1'b0, 1'b1);
    check("die_state",  16'(bus.state), 2);
    check("die_status", 16'(bus.game_status), 0);
    check("die_pos",    16'(bus.ground_position), exp_pos_wrap);
    check("die_speed",  16'(bus.speed), exp_spd_1200);
    frames(29);
    check("die_state_29", 16'(bus.state), 2);
    check("die_pos_29",   16'(bus.ground_position), exp_pos_wrap);
    frames(1);
    check("over_state", 16'(bus.state), 3);
    check("over_pos",   16'(bus.ground_position), exp_pos_wrap);
    frames(1);
    check("over_pos_frozen", 16'(bus.ground_position), exp_pos_wrap);

    // Restart from OVER
    pulse_start();
    check("restart_state", 16'(bus.state), 0);
    check("restart_pos",   16'(bus.ground_position), 0);
    check("restart_speed", 16'(bus.speed), 3);

    // collide ignored in READY
    @(negedge clk);
    bus.collide = 1'b1;
    @(negedge clk);
    bus.collide = 1'b0;
    check("ready_collide_ignored", 16'(bus.state), 0);

    // start coinciding with a tick: scrolls by SPEED_INIT and enters RUN
    frame(1'b0, 1'b1, 1'b1);
    check("start_tick_state", 16'(bus.state), 1);
    check("start_tick_pos",   16'(bus.ground_position), 3);
    frames(2);
    check("run2_pos", 16'(bus.ground_position), 9);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_state",  16'(bus.state), 0);
    check("arst_status", 16'(bus.game_status), 0);
    check("arst_pos",    16'(bus.ground_position), 0);
    check("arst_speed",  16'(bus.speed), 3);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("arst_no_tick", 16'(bus.frame_tick), 0);
    end
    frame(1'b0, 1'b0, 1'b1);
    check("arst_pos_1",   16'(bus.ground_position), 3);
    check("arst_state_1", 16'(bus.state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
